serial_frame_receiver: RTL

Serial-to-parallel receiver for the framed bitstream emitted by the universal shift register's serial-out path. It detects a start bit, shifts in WIDTH data bits (LSB- or MSB-first), checks an optional even-parity bit and the stop bit, then presents the word on a valid/ready output port. It sits downstream of the shift-register transmitter and feeds parallel consumers.

---
 rtl/serial_frame_receiver_pkg.sv | 15 +
 rtl/serial_frame_receiver_shift_core.sv | 44 ++++
 rtl/serial_frame_receiver.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state codes and line levels.
package serial_frame_receiver_pkg;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 2'd0;
  localparam rx_state_t ST_DATA   = 2'd1;
  localparam rx_state_t ST_PARITY = 2'd2;
  localparam rx_state_t ST_STOP   = 2'd3;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_shift_core.sv
// rx_shift_core: bit counter plus a shift register whose direction is latched at frame start.
module rx_shift_core
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             shift,
  input  logic             msb_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;
  logic          msb_dir;

  // Start empties the register and latches bit order; each shift moves one data bit in.
  always_ff @(posedge clk) begin
    if (clear) begin
      data    <= '0;
      cnt     <= '0;
      msb_dir <= 1'b0;
    end else if (start) begin
      data    <= '0;
      cnt     <= '0;
      msb_dir <= msb_first;
    end else if (shift) begin
      if (msb_dir) begin
        data <= {data[WIDTH-2:0], bit_in};
      end else begin
        data <= {bit_in, data[WIDTH-1:1]};
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start/data/parity/stop framing, even-parity check, valid/ready output.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             msb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  rx_state_t        state;
  logic             perr;
  logic [WIDTH-1:0] shift_data;
  logic             shift_last;
  logic             core_start;
  logic             core_shift;

  assign core_start = sin_en && (state == ST_IDLE) && (sin == START_BIT);
  assign core_shift = sin_en && (state == ST_DATA);

  rx_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .clear     (clear),
    .start     (core_start),
    .shift     (core_shift),
    .msb_first (msb_first),
    .bit_in    (sin),
    .data      (shift_data),
    .last      (shift_last)
  );

  // Frame FSM advancing on strobes, plus the output holding register and error pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_IDLE;
      perr       <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (sin_en) begin
        case (state)
          ST_IDLE: begin
            if (sin == START_BIT) begin
              state <= ST_DATA;
              perr  <= 1'b0;
            end
          end
          ST_DATA: begin
            if (shift_last) begin
              state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            perr  <= (^shift_data) ^ sin;
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (sin == STOP_BIT) begin
              if (!out_valid || out_ready) begin
                out_data   <= shift_data;
                parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
                out_valid  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
